// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history (gshare) branch direction predictor.
//
// A pattern history table (PHT) of 2-bit counters is indexed with
// pc[HL+1:2] ^ GBHR. After reset the FSM walks the whole PHT and writes
// weakly-not-taken (2'b01) into every entry. Only then does it enter READY,
// where reads, EX write-backs and history updates take effect.
//
// Optional feature (macro BP_WRITE_BYPASS_EN):
//   defined   - a read on the same edge as a write to the same index returns
//               the value being written. The read uses the repaired history
//               when a repair happens on that edge.
//   undefined - that read returns the stored (old) counter and uses the
//               pre-repair history.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   pc_if, stall_if        fetch PC; stall holds the ID-side outputs
//   id_branch              branch in ID, shifts the speculative history
//   gbp_predict_id         registered PHT counter (bit 1 = predict taken)
//   gbhr_id                history used to form that prediction's index
//   bp_ready               PHT initialisation complete
//   ex_update, ex_actual,  EX resolution: write-back enable, direction,
//   ex_wrong               misprediction flag
//   ex_gbp_predict_update  counter value written back verbatim
//   ex_gbhr_old, pc_ex     history and PC the resolving branch used
module gshare_predictor #(
    parameter int unsigned PC_LENGTH             = 32,
    parameter int unsigned GSHARE_HISTORY_LENGTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PC_LENGTH-1:0]             pc_if,
    input  logic                             stall_if,
    input  logic                             id_branch,
    output logic [1:0]                       gbp_predict_id,
    output logic [GSHARE_HISTORY_LENGTH-1:0] gbhr_id,
    output logic                             bp_ready,
    input  logic                             ex_update,
    input  logic                             ex_actual,
    input  logic                             ex_wrong,
    input  logic [1:0]                       ex_gbp_predict_update,
    input  logic [GSHARE_HISTORY_LENGTH-1:0] ex_gbhr_old,
    input  logic [PC_LENGTH-1:0]             pc_ex
);

    localparam int unsigned HL    = GSHARE_HISTORY_LENGTH;
    localparam int unsigned DEPTH = 2 ** HL;

    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [HL-1:0] init_cnt_q, init_cnt_d;
    logic [HL-1:0] gbhr_q, gbhr_d;
    logic [1:0]    pred_q;
    logic [HL-1:0] gbhr_id_q;
    logic          bp_ready_q;

    logic [1:0]    pht [DEPTH];

    logic          is_ready;
    logic          repair;
    logic [HL-1:0] repaired_hist;
    logic [HL-1:0] rd_hist;
    logic [HL-1:0] rd_idx;
    logic [HL-1:0] ex_idx;
    logic [1:0]    rd_val;
    logic          wr_en;
    logic [HL-1:0] wr_idx;
    logic [1:0]    wr_data;

    // Upper and lowest PC bits do not take part in the index.
    logic unused_pc;
    assign unused_pc = ^{pc_if[PC_LENGTH-1:HL+2], pc_if[1:0],
                         pc_ex[PC_LENGTH-1:HL+2], pc_ex[1:0]};

    assign is_ready      = (state_q == READY);
    assign repair        = ex_update && ex_wrong;
    assign repaired_hist = {ex_gbhr_old[HL-2:0], ex_actual};
    assign ex_idx        = pc_ex[HL+1:2] ^ ex_gbhr_old;

`ifdef BP_WRITE_BYPASS_EN
    assign rd_hist = repair ? repaired_hist : gbhr_q;
`else
    assign rd_hist = gbhr_q;
`endif

    assign rd_idx = pc_if[HL+1:2] ^ rd_hist;

    always_comb begin
        rd_val = pht[rd_idx];
`ifdef BP_WRITE_BYPASS_EN
        if (ex_update && (rd_idx == ex_idx)) begin
            rd_val = ex_gbp_predict_update;
        end
`endif
    end

    // Single write port: the init sweep owns it until READY, then EX write-back.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ex_idx;
        wr_data = ex_gbp_predict_update;
        if (!is_ready) begin
            wr_en   = 1'b1;
            wr_idx  = init_cnt_q;
            wr_data = 2'b01;
        end else if (ex_update) begin
            wr_en = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (!is_ready) begin
            init_cnt_d = init_cnt_q + HL'(1);
            if (&init_cnt_q) begin
                state_d = READY;
            end
        end
    end

    // Repair wins over a same-cycle speculative shift.
    always_comb begin
        gbhr_d = gbhr_q;
        if (is_ready) begin
            if (repair) begin
                gbhr_d = repaired_hist;
            end else if (id_branch) begin
                gbhr_d = {gbhr_q[HL-2:0], pred_q[1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            gbhr_q     <= '0;
            pred_q     <= 2'b01;
            gbhr_id_q  <= '0;
            bp_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            gbhr_q     <= gbhr_d;
            bp_ready_q <= is_ready;
            if (is_ready && !stall_if) begin
                pred_q    <= rd_val;
                gbhr_id_q <= rd_hist;
            end
        end
    end

    // PHT contents are not reset; the init sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pht[wr_idx] <= wr_data;
        end
    end

    assign gbp_predict_id = pred_q;
    assign gbhr_id        = gbhr_id_q;
    assign bp_ready       = bp_ready_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Testbench for gshare_predictor (HL = 8). A table-level reference model
// (PHT array, history register, edge count since reset) predicts every output
// after every clock edge. Directed steps cover the reset, idle, write/read,
// speculation, repair-priority, collision and mid-run reset cases, with a
// randomized section in between.
module tb_gshare_predictor;

    localparam int unsigned PCL = 32;
    localparam int unsigned HL  = 8;

    logic          clk;
    logic          rst;
    logic [31:0]   pc_if;
    logic          stall_if;
    logic          id_branch;
    logic [1:0]    gbp_predict_id;
    logic [7:0]    gbhr_id;
    logic          bp_ready;
    logic          ex_update;
    logic          ex_actual;
    logic          ex_wrong;
    logic [1:0]    ex_gbp_predict_update;
    logic [7:0]    ex_gbhr_old;
    logic [31:0]   pc_ex;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] m_pht [256];
    logic [7:0] m_ghr;
    logic [1:0] m_pred;
    logic [7:0] m_gid;
    int         m_edges;

    gshare_predictor #(
        .PC_LENGTH             (PCL),
        .GSHARE_HISTORY_LENGTH (HL)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pc_if                 (pc_if),
        .stall_if              (stall_if),
        .id_branch             (id_branch),
        .gbp_predict_id        (gbp_predict_id),
        .gbhr_id               (gbhr_id),
        .bp_ready              (bp_ready),
        .ex_update             (ex_update),
        .ex_actual             (ex_actual),
        .ex_wrong              (ex_wrong),
        .ex_gbp_predict_update (ex_gbp_predict_update),
        .ex_gbhr_old           (ex_gbhr_old),
        .pc_ex                 (pc_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_ghr   = 8'h00;
        m_pred  = 2'b01;
        m_gid   = 8'h00;
    endtask

    // One rising edge worth of behaviour, from the current input values.
    function automatic void model_edge();
        logic [7:0] wi;
        logic [7:0] ri;
        logic [7:0] hrd;
        logic       rep;
        logic [1:0] val;
        logic       shift_bit;
        if (m_edges < 256) begin
            m_pht[m_edges] = 2'b01;
        end else begin
            rep = ex_update && ex_wrong;
            wi  = pc_ex[9:2] ^ ex_gbhr_old;
            hrd = m_ghr;
`ifdef BP_WRITE_BYPASS_EN
            if (rep) hrd = {ex_gbhr_old[6:0], ex_actual};
`endif
            ri        = pc_if[9:2] ^ hrd;
            shift_bit = m_pred[1];
            if (!stall_if) begin
                val = m_pht[ri];
`ifdef BP_WRITE_BYPASS_EN
                if (ex_update && ri == wi) val = ex_gbp_predict_update;
`endif
                m_pred = val;
                m_gid  = hrd;
            end
            if (ex_update) m_pht[wi] = ex_gbp_predict_update;
            if (rep) m_ghr = {ex_gbhr_old[6:0], ex_actual};
            else if (id_branch) m_ghr = {m_ghr[6:0], shift_bit};
        end
        m_edges++;
    endfunction

    task automatic compare_all();
        chk("pred", {30'd0, gbp_predict_id}, {30'd0, m_pred});
        chk("gbhr_id", {24'd0, gbhr_id}, {24'd0, m_gid});
        chk("bp_ready", {31'd0, bp_ready}, {31'd0, (m_edges >= 257)});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        stall_if              = 1'b0;
        id_branch             = 1'b0;
        ex_update             = 1'b0;
        ex_actual             = 1'b0;
        ex_wrong              = 1'b0;
        ex_gbp_predict_update = 2'b00;
        ex_gbhr_old           = 8'h00;
        pc_ex                 = 32'h0;
        pc_if                 = 32'h0;
    endtask

    task automatic init_phase(input string tag);
        // EX and ID activity must be ignored while the table initialises.
        for (int i = 0; i < 256; i++) begin
            pc_if                 = $urandom;
            id_branch             = 1'($urandom_range(0, 1));
            ex_update             = 1'($urandom_range(0, 1));
            ex_wrong              = 1'($urandom_range(0, 1));
            ex_actual             = 1'($urandom_range(0, 1));
            ex_gbp_predict_update = 2'($urandom_range(0, 3));
            ex_gbhr_old           = 8'($urandom_range(0, 255));
            pc_ex                 = $urandom;
            step();
            chk({tag, "_busy"}, {31'd0, bp_ready}, 32'd0);
        end
        idle_inputs();
        step();
        chk({tag, "_ready"}, {31'd0, bp_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        chk("rst_pred", {30'd0, gbp_predict_id}, 32'd1);
        chk("rst_gbhr_id", {24'd0, gbhr_id}, 32'd0);
        chk("rst_bp_ready", {31'd0, bp_ready}, 32'd0);
        #10;
        rst = 1'b0;

        init_phase("init");

        // Any PC reads weakly-not-taken after initialisation
        for (int i = 0; i < 8; i++) begin
            pc_if = $urandom;
            step();
            chk("idle_read", {30'd0, gbp_predict_id}, 32'd1);
        end

        // Write 2'b11 at idx 0x10, then read it back
        pc_if = 32'h0;
        ex_update = 1'b1; pc_ex = 32'h40; ex_gbhr_old = 8'h00; ex_gbp_predict_update = 2'b11;
        step();
        ex_update = 1'b0; pc_if = 32'h40;
        step();
        chk("wr_rd", {30'd0, gbp_predict_id}, 32'd3);

        // Speculation: need prediction 2'b10 with GBHR 0
        ex_update = 1'b1; pc_ex = 32'h80; ex_gbhr_old = 8'h00; ex_gbp_predict_update = 2'b10;
        step();
        ex_update = 1'b0; pc_if = 32'h80;
        step();
        chk("spec_pred", {30'd0, gbp_predict_id}, 32'd2);
        id_branch = 1'b1;
        step();
        chk("spec_gid0", {24'd0, gbhr_id}, 32'h00);
        step();
        chk("spec_gid1", {24'd0, gbhr_id}, 32'h01);
        id_branch = 1'b0;
        step();
        chk("spec_gid3", {24'd0, gbhr_id}, 32'h03);

        // Repair beats a same-cycle shift
        id_branch = 1'b1; ex_update = 1'b1; ex_wrong = 1'b1; ex_actual = 1'b0;
        ex_gbhr_old = 8'h5A; pc_ex = 32'h0; ex_gbp_predict_update = 2'b01;
        step();
        idle_inputs();
        step();
        chk("repair", {24'd0, gbhr_id}, 32'hB4);

        // Collision at idx 0x10 (GBHR is 0xB4, so pc_if[9:2] = 0xA4)
        pc_if = 32'h290;
        ex_update = 1'b1; pc_ex = 32'h40; ex_gbhr_old = 8'h00; ex_gbp_predict_update = 2'b00;
        step();
`ifdef BP_WRITE_BYPASS_EN
        chk("collide", {30'd0, gbp_predict_id}, 32'd0);
`else
        chk("collide", {30'd0, gbp_predict_id}, 32'd3);
`endif
        ex_update = 1'b0;
        step();
        chk("collide_reread", {30'd0, gbp_predict_id}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            pc_if                 = $urandom;
            stall_if              = ($urandom_range(0, 3) == 0);
            id_branch             = 1'($urandom_range(0, 1));
            ex_update             = 1'($urandom_range(0, 1));
            ex_actual             = 1'($urandom_range(0, 1));
            ex_wrong              = ($urandom_range(0, 2) == 0);
            ex_gbp_predict_update = 2'($urandom_range(0, 3));
            ex_gbhr_old           = 8'($urandom_range(0, 255));
            pc_ex                 = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                pc_ex       = pc_if;
                ex_gbhr_old = m_ghr;
            end
            step();
        end

        // Mid-run reset: plant 2'b11 at idx 0x10 first
        idle_inputs();
        ex_update = 1'b1; pc_ex = 32'h40; ex_gbhr_old = 8'h00; ex_gbp_predict_update = 2'b11;
        step();
        ex_update = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mrst_pred", {30'd0, gbp_predict_id}, 32'd1);
        chk("mrst_gbhr_id", {24'd0, gbhr_id}, 32'd0);
        chk("mrst_bp_ready", {31'd0, bp_ready}, 32'd0);
        #2;
        rst = 1'b0;
        init_phase("reinit");
        pc_if = 32'h40;
        step();
        chk("mrst_entry", {30'd0, gbp_predict_id}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
